// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: modes, opcodes, ALU commands,
// registered control bundle and FSM states.
package ctrl_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic wb_en;
    logic branch;
    logic s_out;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_DECODE   = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_BUBBLE   = 2'b10
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode -> 4-bit ALU command, mode -> controls.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [1:0]          mode,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                s_in,
  output logic [3:0]          alu_cmd,
  output ctrl_t               ctrl
);

  logic [3:0] op4;
  logic       hi_set;

  assign op4    = opcode[3:0];
  // any upper opcode bit set forces the default decode
  assign hi_set = (opcode >> 4) != '0;

  // opcode table lookup; CMP/TST suppress write-back in data processing
  always_comb begin
    alu_cmd = ALU_MOV;
    ctrl    = '0;
    if (!hi_set) begin
      unique case (op4)
        OP_MOV:  alu_cmd = ALU_MOV;
        OP_MVN:  alu_cmd = ALU_MVN;
        OP_ADD:  alu_cmd = ALU_ADD;
        OP_ADC:  alu_cmd = ALU_ADC;
        OP_SUB:  alu_cmd = ALU_SUB;
        OP_SBC:  alu_cmd = ALU_SBC;
        OP_AND:  alu_cmd = ALU_AND;
        OP_ORR:  alu_cmd = ALU_ORR;
        OP_EOR:  alu_cmd = ALU_EOR;
        OP_CMP:  alu_cmd = ALU_SUB;
        OP_TST:  alu_cmd = ALU_AND;
        default: alu_cmd = ALU_MOV;
      endcase
    end
    unique case (mode)
      MODE_DP: begin
        ctrl.s_out = s_in;
        ctrl.wb_en = hi_set || !(op4 == OP_CMP || op4 == OP_TST);
      end
      MODE_MEM: begin
        ctrl.wb_en     = s_in;
        ctrl.mem_read  = s_in;
        ctrl.mem_write = ~s_in;
      end
      MODE_BR:  ctrl.branch = 1'b1;
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered control sequencer: decode, memory handshake with timeout,
// post-branch bubbles and flush.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 4,
  parameter int ALU_CMD_W     = 4,
  parameter int BUBBLE_CYCLES = 1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 s_in,
  output logic                 out_valid,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_en,
  output logic                 branch,
  output logic                 s_out,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 mem_err,
  output logic                 stall
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wcnt_q, wcnt_d;
  logic [2:0]           bcnt_q, bcnt_d;
  ctrl_t                ctrl_q, ctrl_d, dec_ctrl;
  logic [ALU_CMD_W-1:0] alu_q, alu_d;
  logic [3:0]           dec_alu;
  logic                 req_q, req_d, vld_q, vld_d, err_q, err_d;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .mode    (mode),
    .opcode  (opcode),
    .s_in    (s_in),
    .alu_cmd (dec_alu),
    .ctrl    (dec_ctrl)
  );

  assign in_ready  = (state_q == ST_DECODE);
  assign stall     = ~in_ready;
  assign out_valid = vld_q;
  assign alu_cmd   = alu_q;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign wb_en     = ctrl_q.wb_en;
  assign branch    = ctrl_q.branch;
  assign s_out     = ctrl_q.s_out;
  assign mem_req   = req_q;
  assign mem_err   = err_q;

  // next-state and next-register computation; flush overrides everything
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    req_d   = req_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_DECODE: begin
        wcnt_d = '0;
        if (in_valid) begin
          vld_d  = 1'b1;
          ctrl_d = dec_ctrl;
          alu_d  = ALU_CMD_W'(dec_alu);
          if (mode == MODE_MEM) begin
            state_d = ST_MEM_WAIT;
            req_d   = 1'b1;
          end else if (mode == MODE_BR && BUBBLE_CYCLES > 0) begin
            state_d = ST_BUBBLE;
            bcnt_d  = 3'(BUBBLE_CYCLES);
          end
        end
      end
      ST_MEM_WAIT: begin
        if (wcnt_q != CNT_W'(MEM_TIMEOUT)) wcnt_d = wcnt_q + 1'b1;
        if (mem_ack) begin
          // ack takes precedence over a coincident timeout
          req_d   = 1'b0;
          wcnt_d  = '0;
          state_d = ST_DECODE;
        end else if (wcnt_q >= CNT_W'(MEM_TIMEOUT - 1)) begin
          req_d            = 1'b0;
          wcnt_d           = '0;
          err_d            = 1'b1;
          ctrl_d.wb_en     = 1'b0;
          ctrl_d.mem_read  = 1'b0;
          ctrl_d.mem_write = 1'b0;
          state_d          = ST_DECODE;
        end
      end
      ST_BUBBLE: begin
        if (bcnt_q <= 3'd1) begin
          bcnt_d  = '0;
          state_d = ST_DECODE;
        end else begin
          bcnt_d = bcnt_q - 3'd1;
        end
      end
      default: state_d = ST_DECODE;
    endcase
    if (flush) begin
      state_d = ST_DECODE;
      wcnt_d  = '0;
      bcnt_d  = '0;
      ctrl_d  = '0;
      alu_d   = '0;
      req_d   = 1'b0;
      vld_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_DECODE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench: dut has 2 bubbles / timeout 4, dut0 has no bubbles.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_valid0, s_in, mem_ack;
  logic [1:0] mode;
  logic [3:0] opcode;

  logic       in_ready, out_valid, mem_read, mem_write, wb_en, branch, s_out, mem_req, mem_err, stall;
  logic [3:0] alu_cmd;
  logic       in_ready0, out_valid0, mem_read0, mem_write0, wb_en0, branch0, s_out0, mem_req0, mem_err0, stall0;
  logic [3:0] alu_cmd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.OPCODE_W(4), .ALU_CMD_W(4), .BUBBLE_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .opcode(opcode), .s_in(s_in), .out_valid(out_valid), .alu_cmd(alu_cmd),
    .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .branch(branch), .s_out(s_out),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_err(mem_err), .stall(stall)
  );

  ctrl_sequencer #(.OPCODE_W(4), .ALU_CMD_W(4), .BUBBLE_CYCLES(0), .MEM_TIMEOUT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .mode(mode), .opcode(opcode), .s_in(s_in), .out_valid(out_valid0), .alu_cmd(alu_cmd0),
    .mem_read(mem_read0), .mem_write(mem_write0), .wb_en(wb_en0), .branch(branch0), .s_out(s_out0),
    .mem_req(mem_req0), .mem_ack(mem_ack), .mem_err(mem_err0), .stall(stall0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op, input logic s);
    in_valid = v; mode = m; opcode = op; s_in = s;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid0 = 1'b0; mem_ack = 1'b0;
    drive(1'b0, 2'b11, 4'h0, 1'b0);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ctrl", {alu_cmd, mem_read, mem_write, wb_en, branch, s_out, mem_err}, 0);
    rst_n = 1'b1;

    // ADD then CMP back to back
    drive(1'b1, 2'b00, 4'b0100, 1'b1);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_alu", alu_cmd, 4'b0010);
    chk("add_wb", wb_en, 1);
    chk("add_s", s_out, 1);
    drive(1'b1, 2'b00, 4'b1010, 1'b1);
    step();
    chk("cmp_valid", out_valid, 1);
    chk("cmp_alu", alu_cmd, 4'b0100);
    chk("cmp_wb", wb_en, 0);
    chk("cmp_stall", stall, 0);
    // unlisted opcode
    drive(1'b1, 2'b00, 4'b0011, 1'b0);
    step();
    chk("dflt_alu", alu_cmd, 4'b0001);
    chk("dflt_wb_s", {wb_en, s_out}, 2'b10);

    // LDR, ack in 4th request cycle
    drive(1'b1, 2'b01, 4'b0100, 1'b1);
    step();
    chk("ldr_valid", out_valid, 1);
    chk("ldr_req", mem_req, 1);
    chk("ldr_ready", in_ready, 0);
    chk("ldr_ctrl", {wb_en, mem_read, mem_write}, 3'b110);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("ldr_req_hold", {mem_req, in_ready, out_valid}, 3'b100);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ldr_ack_req", mem_req, 0);
    chk("ldr_ack_ready", in_ready, 1);
    chk("ldr_ack_ctrl", {wb_en, mem_read, mem_err}, 3'b110);

    // STR with ack in the first request cycle
    drive(1'b1, 2'b01, 4'b0100, 1'b0);
    step();
    chk("str_ctrl", {mem_write, wb_en, mem_read, mem_req}, 4'b1001);
    in_valid = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("str_done", {mem_req, in_ready}, 2'b01);

    // LDR timing out after 4 unacknowledged cycles
    drive(1'b1, 2'b01, 4'b0100, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("to_wait", {mem_req, mem_err}, 2'b10);
    end
    step();
    chk("to_err", mem_err, 1);
    chk("to_cleared", {mem_req, wb_en, mem_read, mem_write}, 0);
    chk("to_ready", in_ready, 1);
    step();
    chk("to_err_pulse", mem_err, 0);

    // branch with 2 bubbles, offered instructions are squashed
    drive(1'b1, 2'b10, 4'b0000, 1'b0);
    step();
    chk("br_valid", {out_valid, branch, in_ready}, 3'b110);
    drive(1'b1, 2'b00, 4'b1101, 1'b0);
    step();
    chk("br_bub1", {out_valid, branch, in_ready}, 3'b010);
    step();
    chk("br_bub2", {out_valid, in_ready}, 2'b01);
    in_valid = 1'b0;
    step();
    chk("br_squashed", out_valid, 0);

    // branch on the zero-bubble instance
    in_valid0 = 1'b1; mode = 2'b10; opcode = 4'b0000;
    step();
    chk("br0_valid", {out_valid0, branch0, in_ready0}, 3'b111);
    in_valid0 = 1'b0;
    step();
    chk("br0_after", {out_valid0, in_ready0}, 2'b01);

    // flush during MEM_WAIT with an instruction offered
    drive(1'b1, 2'b01, 4'b0100, 1'b1);
    step();
    flush = 1'b1;
    drive(1'b1, 2'b00, 4'b0100, 1'b1);
    step();
    chk("fl_mw_req_rdy", {mem_req, in_ready, out_valid}, 3'b010);
    chk("fl_mw_ctrl", {alu_cmd, mem_read, mem_write, wb_en, branch, s_out, mem_err}, 0);
    // flush in DECODE drops the same-cycle accept
    step();
    chk("fl_dec_drop", {out_valid, alu_cmd, wb_en}, 0);
    flush = 1'b0; in_valid = 1'b0;

    // reset mid MEM_WAIT
    drive(1'b1, 2'b01, 4'b0100, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mw_out", {mem_req, mem_err, out_valid, wb_en, mem_read}, 0);
    chk("rst_mw_ready", {in_ready, stall}, 2'b10);
    step();
    chk("rst_mw_noerr", {mem_err, mem_req}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
